// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between execute stage and the multiply/divide unit
interface mult_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  hi_we;
    logic                  lo_we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, hi_we, lo_we, wdata,
        output hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative shift-add multiplier / restoring divider with HI/LO registers
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    mult_div_unit_if.slave   bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            is_div_q;
    logic [W-1:0]    operand_q;   // multiplicand magnitude or divisor magnitude
    logic [2*W-1:0]  work_q;      // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [CW-1:0]   count_q;
    logic            neg_lo_q;    // product sign (mult) or quotient sign (div)
    logic            neg_hi_q;    // remainder sign (div)
    logic [W-1:0]    hi_q, lo_q;
    logic            done_q;
    logic            dbz_q;

    logic            accept;
    logic            last_step;
    logic            sign_a, sign_b;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mult_sum;
    logic [2*W-1:0]  mult_next;
    logic [2*W:0]    div_shift;
    logic [W:0]      div_trial;
    logic [2*W-1:0]  div_next;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quot_fix, rem_fix;
    logic            res_dbz;
    logic [W-1:0]    res_hi, res_lo;

    assign accept    = (state_q == S_IDLE) && bus.start;
    assign last_step = (count_q == CW'(W - 1));

    // Operand signs only matter for the signed ops (op[0] == 0); magnitudes feed the unsigned core.
    always_comb begin
        sign_a = bus.operand_a[W-1] & ~bus.op[0];
        sign_b = bus.operand_b[W-1] & ~bus.op[0];
        mag_a  = sign_a ? (~bus.operand_a + W'(1)) : bus.operand_a;
        mag_b  = sign_b ? (~bus.operand_b + W'(1)) : bus.operand_b;
    end

    // One iteration of each algorithm; the RUN state picks the one matching the latched op.
    always_comb begin
        mult_sum  = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, operand_q} : {(W+1){1'b0}});
        mult_next = {mult_sum, work_q[W-1:1]};
        div_shift = {work_q, 1'b0};
        div_trial = div_shift[2*W:W] - {1'b0, operand_q};
        div_next  = div_trial[W] ? div_shift[2*W-1:0]
                                 : {div_trial[W-1:0], div_shift[W-1:1], 1'b1};
    end

    // Sign correction and divide-by-zero override applied while in FINISH.
    always_comb begin
        prod_fix = neg_lo_q ? (~work_q + (2*W)'(1)) : work_q;
        quot_fix = neg_lo_q ? (~work_q[W-1:0] + W'(1)) : work_q[W-1:0];
        rem_fix  = neg_hi_q ? (~work_q[2*W-1:W] + W'(1)) : work_q[2*W-1:W];
        res_dbz  = is_div_q && (operand_q == '0);
        if (is_div_q) begin
            res_hi = rem_fix;
            res_lo = res_dbz ? {W{1'b1}} : quot_fix;
        end else begin
            res_hi = prod_fix[2*W-1:W];
            res_lo = prod_fix[W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state and busy output.
    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_RUN;
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (last_step) state_d = S_FINISH;
            end
            S_FINISH: begin
                bus.busy = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO update and completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_q  <= 1'b0;
            operand_q <= '0;
            work_q    <= '0;
            count_q   <= '0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (accept) begin
                        is_div_q  <= bus.op[1];
                        operand_q <= bus.op[1] ? mag_b : mag_a;
                        work_q    <= {{W{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                        count_q   <= '0;
                        neg_lo_q  <= sign_a ^ sign_b;
                        neg_hi_q  <= sign_a;
                    end
                end
                S_RUN: begin
                    work_q  <= is_div_q ? div_next : mult_next;
                    count_q <= count_q + CW'(1);
                end
                S_FINISH: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                    dbz_q  <= res_dbz;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    mult_div_unit_if #(.DATA_WIDTH(32)) bus ();
    mult_div_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic edz);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up, v;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        edz = 1'b0;
        case (op)
            2'b00: begin sp = sa * sb; v = sp; eh = v[63:32]; el = v[31:0]; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; eh = up[63:32]; el = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF; eh = a; edz = 1'b1;
                end else if (op == 2'b10) begin
                    sq = sa / sb; sr = sa % sb;
                    v = sq; el = v[31:0];
                    v = sr; eh = v[31:0];
                end else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (bus.done) break;
        end
        if (!bus.done) begin
            n_checks++; n_errors++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
    endtask

    // Drives a request from the current (post-edge) point, so back-to-back calls start in the done cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit mt);
        logic [31:0] eh, el;
        logic        edz;
        int          n;
        model(op, a, b, eh, el, edz);
        bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_busy"}, {63'b0, bus.busy}, 64'd1);
        check({tag, "_done_low"}, {63'b0, bus.done}, 64'd0);
        if (mt) check({tag, "_mthi_e0"}, {32'b0, bus.hi}, {32'b0, bus.wdata});
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        wait_done(n);
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_hi"}, {32'b0, bus.hi}, {32'b0, eh});
        check({tag, "_lo"}, {32'b0, bus.lo}, {32'b0, el});
        check({tag, "_dbz"}, {63'b0, bus.div_by_zero}, {63'b0, edz});
        check({tag, "_busy_end"}, {63'b0, bus.busy}, 64'd0);
    endtask

    initial begin
        int          n;
        logic [31:0] a, b;
        logic [1:0]  op;
        bus.start = 0; bus.op = 0; bus.operand_a = 0; bus.operand_b = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_hi", {32'b0, bus.hi}, 64'd0);
        check("rst_lo", {32'b0, bus.lo}, 64'd0);
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_hi_c", {32'b0, bus.hi}, 64'hFFFF_FFFE);
        check("multu_max_lo_c", {32'b0, bus.lo}, 64'h1);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h7, 0);
        check("mult_neg_lo_c", {32'b0, bus.lo}, 64'hFFFF_FFEB);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h2, 0);
        check("div_neg_lo_c", {32'b0, bus.lo}, 64'hFFFF_FFFD);
        check("div_neg_hi_c", {32'b0, bus.hi}, 64'hFFFF_FFFF);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 0);
        check("divu_100_7_lo_c", {32'b0, bus.lo}, 64'h0E);
        run_op("divu_zero", 2'b11, 32'h64, 32'h0, 0);
        check("divu_zero_hi_c", {32'b0, bus.hi}, 64'h64);
        run_op("div_zero_neg", 2'b10, 32'h8000_0005, 32'h0, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_lo_c", {32'b0, bus.lo}, 64'h8000_0000);
        check("div_ovf_dbz_c", {63'b0, bus.div_by_zero}, 64'd0);

        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h1234_5678;
        run_op("mt_with_start", 2'b01, 32'd6, 32'd7, 1);

        // start and MTHI while busy are both dropped
        bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd3; bus.operand_b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'd99; bus.operand_b = 32'd4;
        bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hi_we = 1'b0;
        wait_done(n);
        check("busy_ign_latency", 64'(n + 5), 64'd33);
        check("busy_ign_hi", {32'b0, bus.hi}, 64'h0);
        check("busy_ign_lo", {32'b0, bus.lo}, 64'h0F);
        @(posedge clk); #1;
        check("busy_ign_no_restart", {63'b0, bus.busy}, 64'd0);

        bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        check("mthi_hi", {32'b0, bus.hi}, 64'hDEAD);
        check("mthi_lo_hold", {32'b0, bus.lo}, 64'h0F);
        bus.lo_we = 1'b1; bus.wdata = 32'hBEEF;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        check("mtlo_lo", {32'b0, bus.lo}, 64'hBEEF);
        check("mtlo_hi_hold", {32'b0, bus.hi}, 64'hDEAD);

        // reset mid-operation
        bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", {63'b0, bus.busy}, 64'd0);
        check("midrst_hi", {32'b0, bus.hi}, 64'd0);
        check("midrst_lo", {32'b0, bus.lo}, 64'd0);
        check("midrst_done", {63'b0, bus.done}, 64'd0);
        run_op("after_rst", 2'b11, 32'd1000, 32'd3, 0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
            run_op($sformatf("rnd%0d", i), op, a, b, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
